// File: rtl/rr_arb_mux_pkg.sv
// Shared types and constants for the round-robin arbitrating mux.
package rr_arb_mux_pkg;

  typedef enum logic {
    MODE_RR    = 1'b0,
    MODE_FIXED = 1'b1
  } arb_mode_e;

  // Reset pointer sits on the last channel so channel 0 is searched first.
  function automatic int rst_ptr(input int nch);
    return nch - 1;
  endfunction

endpackage

// File: rtl/rr_arb_mux_if.sv
// Request/response bundle between requesters, the arbitrating mux and the consumer.
interface rr_arb_mux_if #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4
) ();
  localparam int SELW = $clog2(NCH);

  logic [NCH-1:0]       in_valid;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_ready;
  logic                 force_en;
  logic [SELW-1:0]      force_sel;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_sel;
  logic                 out_ready;

  modport slave (
    input  in_valid, in_data, force_en, force_sel, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in_valid, in_data, force_en, force_sel, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_arb_mux_arbiter.sv
// Combinational round-robin search starting one past ptr, wrapping modulo NCH.
module rr_arb_mux_arbiter #(
  parameter int NCH  = 4,
  parameter int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  input  logic            en,
  output logic [NCH-1:0]  gnt,
  output logic [SELW-1:0] gnt_idx,
  output logic            any
);

  logic [SELW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = SELW'((int'(ptr) + k) % NCH);
      if (en && !any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel arbitrating mux: round-robin or forced select, winner registered behind valid/ready.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NCH   = 4
) (
  input logic          clk,
  input logic          reset,
  rr_arb_mux_if.slave  bus
);
  localparam int SELW = $clog2(NCH);
  localparam logic [SELW-1:0] PTR_RST = SELW'(rst_ptr(NCH));

  arb_mode_e        mode;
  logic [NCH-1:0]   req_mask;
  logic [NCH-1:0]   gnt;
  logic [SELW-1:0]  gnt_idx;
  logic             any;
  logic             load;
  logic             arb_en;
  logic [WIDTH-1:0] ch_data [NCH];

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_sel_q,   out_sel_d;
  logic [SELW-1:0]  ptr_q,       ptr_d;

  assign mode   = arb_mode_e'(bus.force_en);
  assign load   = !out_valid_q || bus.out_ready;
  // Nothing is granted while reset is held, even though the register reads empty.
  assign arb_en = load && !reset;

  // force_sel values >= NCH match no channel, so they never win.
  always_comb begin
    req_mask = '0;
    if (mode == MODE_FIXED) begin
      for (int i = 0; i < NCH; i++) begin
        if (bus.force_sel == SELW'(i)) req_mask[i] = 1'b1;
      end
    end else begin
      req_mask = '1;
    end
  end

  rr_arb_mux_arbiter #(.NCH(NCH), .SELW(SELW)) u_arbiter (
    .req     (bus.in_valid & req_mask),
    .ptr     (ptr_q),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign ch_data[i] = bus.in_data[i*WIDTH +: WIDTH];
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (any) begin
      out_valid_d = 1'b1;
      out_data_d  = ch_data[gnt_idx];
      out_sel_d   = gnt_idx;
      ptr_d       = gnt_idx;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= PTR_RST;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.in_ready  = gnt;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: a 4-channel and a 3-channel instance sharing clock and reset.
module tb_rr_arb_mux;

  logic clk;
  logic reset;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  rr_arb_mux_if #(.WIDTH(32), .NCH(4)) bus4 ();
  rr_arb_mux_if #(.WIDTH(32), .NCH(3)) bus3 ();

  rr_arb_mux #(.WIDTH(32), .NCH(4)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4));
  rr_arb_mux #(.WIDTH(32), .NCH(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    bus4.in_valid  = '0;
    bus4.in_data   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    bus4.force_en  = 1'b0;
    bus4.force_sel = '0;
    bus4.out_ready = 1'b1;
    bus3.in_valid  = '0;
    bus3.in_data   = {32'hA2, 32'hA1, 32'hA0};
    bus3.force_en  = 1'b0;
    bus3.force_sel = '0;
    bus3.out_ready = 1'b1;

    // reset then idle
    repeat (2) tick();
    reset = 1'b0;
    #1;
    chk("rst_valid", 32'(bus4.out_valid), 32'd0);
    chk("rst_data",  bus4.out_data,       32'd0);
    chk("rst_sel",   32'(bus4.out_sel),   32'd0);
    chk("rst_ready", 32'(bus4.in_ready),  32'd0);
    tick();
    chk("idle_valid", 32'(bus4.out_valid), 32'd0);
    chk("idle_ready", 32'(bus4.in_ready),  32'd0);

    // all channels valid, round-robin 0,1,2,3,0,1
    bus4.in_valid = 4'b1111;
    #1;
    chk("rr_first_ready", 32'(bus4.in_ready), 32'h1);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr_sel",   32'(bus4.out_sel),   32'(k % 4));
      chk("rr_data",  bus4.out_data,       32'hA0 + 32'(k % 4));
      chk("rr_valid", 32'(bus4.out_valid), 32'd1);
      chk("rr_ready", 32'(bus4.in_ready),  32'd1 << ((k + 1) % 4));
    end

    // backpressure with A1 held
    bus4.out_ready = 1'b0;
    #1;
    chk("stall_ready0", 32'(bus4.in_ready), 32'd0);
    repeat (3) begin
      tick();
      chk("stall_data",  bus4.out_data,       32'hA1);
      chk("stall_sel",   32'(bus4.out_sel),   32'd1);
      chk("stall_valid", 32'(bus4.out_valid), 32'd1);
      chk("stall_ready", 32'(bus4.in_ready),  32'd0);
    end
    bus4.out_ready = 1'b1;
    #1;
    chk("release_ready", 32'(bus4.in_ready), 32'b0100);
    tick();
    chk("release_sel",  32'(bus4.out_sel), 32'd2);
    chk("release_data", bus4.out_data,     32'hA2);

    // forced channel 2, then back to round-robin resuming after it
    bus4.force_en  = 1'b1;
    bus4.force_sel = 2'd2;
    #1;
    chk("force_ready0", 32'(bus4.in_ready), 32'b0100);
    repeat (3) begin
      tick();
      chk("force_sel",   32'(bus4.out_sel),  32'd2);
      chk("force_ready", 32'(bus4.in_ready), 32'b0100);
    end
    bus4.force_en = 1'b0;
    #1;
    chk("unforce_ready", 32'(bus4.in_ready), 32'b1000);
    tick();
    chk("unforce_sel",  32'(bus4.out_sel), 32'd3);
    chk("unforce_data", bus4.out_data,     32'hA3);

    // sparse requesters 1 and 3 alternate
    bus4.in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("sparse_sel", 32'(bus4.out_sel), (k % 2 == 0) ? 32'd1 : 32'd3);
    end

    // single requester granted back-to-back
    bus4.in_valid = 4'b1000;
    repeat (3) begin
      tick();
      chk("single_sel",   32'(bus4.out_sel),   32'd3);
      chk("single_valid", 32'(bus4.out_valid), 32'd1);
    end

    // drain with no new request: valid drops, data and sel hold
    bus4.in_valid = 4'b0000;
    tick();
    chk("drain_valid", 32'(bus4.out_valid), 32'd0);
    chk("drain_sel",   32'(bus4.out_sel),   32'd3);
    chk("drain_data",  bus4.out_data,       32'hA3);

    // forced channel not requesting: no grant
    bus4.force_en  = 1'b1;
    bus4.force_sel = 2'd1;
    bus4.in_valid  = 4'b1000;
    #1;
    chk("force_idle_ready", 32'(bus4.in_ready), 32'd0);
    tick();
    chk("force_idle_valid", 32'(bus4.out_valid), 32'd0);
    bus4.force_en = 1'b0;

    // reset in the middle of operation
    bus4.in_valid = 4'b1111;
    tick();
    chk("pre_rst_valid", 32'(bus4.out_valid), 32'd1);
    chk("pre_rst_sel",   32'(bus4.out_sel),   32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(bus4.out_valid), 32'd0);
    chk("async_rst_ready", 32'(bus4.in_ready),  32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(bus4.in_ready), 32'h1);
    tick();
    chk("post_rst_sel",  32'(bus4.out_sel), 32'd0);
    chk("post_rst_data", bus4.out_data,     32'hA0);

    // three-channel instance wraps at 3
    bus3.in_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("nch3_sel",  32'(bus3.out_sel), 32'(k % 3));
      chk("nch3_data", bus3.out_data,     32'hA0 + 32'(k % 3));
    end
    bus3.force_en  = 1'b1;
    bus3.force_sel = 2'd3;
    #1;
    chk("nch3_oob_ready", 32'(bus3.in_ready), 32'd0);
    tick();
    chk("nch3_oob_valid", 32'(bus3.out_valid), 32'd0);
    chk("nch3_oob_sel",   32'(bus3.out_sel),   32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
